// File: rtl/imem_boot_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared CPU-side definitions for the instruction memory and its boot loader:
// the loader FSM state encoding, the NOP instruction word and the default
// word-address width.
//
// Build switch: IMEM_CHECKSUM_EN
//   Defined   -> the loader FSM has a CHK state that verifies a trailing XOR
//                checksum byte after the data words.
//   Undefined -> no CHK state; the last data word goes straight to DONE.
// ----------------------------------------------------------------------------
package imem_boot_loader_pkg;

  // Default word-address width (memory depth is 2**ADDR_W words).
  localparam int ADDR_W_DEF = 14;

  // Instruction presented to fetch while a load is in progress.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef IMEM_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5
  } load_state_t;

endpackage

// File: rtl/imem_boot_loader_ram.sv
// ----------------------------------------------------------------------------
// imem_ram
// Simple dual-port instruction RAM: one write port, one synchronous read port,
// read-first on a same-address collision. No reset so it maps onto block RAM.
//
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write word address
//   i_wdata  in   write data
//   i_raddr  in   read word address (sampled on the rising edge)
//   o_rdata  out  read data, one cycle after i_raddr
// ----------------------------------------------------------------------------
module imem_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset branch on purpose; a reset on a memory
  // prevents block-RAM inference and the contents must survive a reset.
  // Non-blocking assignments make the read sample the pre-write value, which
  // is what gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
// Instruction memory feeding the fetch unit, with a UART bootload path.
// A load is a 16-bit big-endian word count followed by that many 32-bit
// big-endian words, written sequentially from address 0. The CPU is held in
// reset and fetch sees NOPs while a load is running.
//
// Build switch: IMEM_CHECKSUM_EN adds a trailing XOR-of-data checksum byte.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   rom_adr_i      in   fetch word address
//   instruction_o  out  instruction for rom_adr_i, one cycle later (NOP if busy)
//   boot_req       in   level, starts a load when the FSM is idle
//   rx_valid       in   one-cycle strobe from the UART receiver
//   rx_byte        in   received byte
//   cpu_rst_o      out  CPU reset hold while loading
//   load_busy      out  load in progress
//   load_done      out  last load completed (sticky until next boot_req)
//   load_err       out  length overflow / checksum error (sticky)
//   words_loaded   out  words written in the current or last load
// ----------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rom_adr_i,
  output logic [31:0]       instruction_o,
  input  logic              boot_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              cpu_rst_o,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  load_state_t       r_state;
  logic              r_hold;     // high in every state except IDLE and DONE
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_words;
  logic [1:0]        r_idx;
  logic [23:0]       r_word;     // first three bytes of the word in flight
  logic [15:0]       r_len;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]        r_chk;
`endif

  logic [15:0]       w_len_rx;
  logic              w_len_over;
  logic [ADDR_W:0]   w_words_nxt;
  logic              w_last;
  logic              w_we;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;

  assign w_len_rx    = {r_len[15:8], rx_byte};
  // Both sides zero-extended to 32 bits so no length can alias into range.
  assign w_len_over  = 32'(w_len_rx) > 32'(MAX_WORDS);
  assign w_words_nxt = r_words + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last      = 32'(w_words_nxt) == 32'(r_len);

  // The 4th byte is written straight from rx_byte in the cycle it arrives.
  assign w_we    = (r_state == S_DATA) && rx_valid && (r_idx == 2'd3);
  assign w_wdata = {r_word, rx_byte};

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_words[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (rom_adr_i),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_words <= '0;
      r_idx   <= 2'd0;
      r_word  <= '0;
      r_len   <= '0;
`ifdef IMEM_CHECKSUM_EN
      r_chk   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (boot_req) begin
            r_state <= S_LEN_HI;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= '0;
            r_idx   <= 2'd0;
`ifdef IMEM_CHECKSUM_EN
            r_chk   <= '0;
`endif
          end
        end

        S_LEN_HI: begin
          if (rx_valid) begin
            r_len[15:8] <= rx_byte;
            r_state     <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (rx_valid) begin
            r_len <= w_len_rx;
            if (w_len_rx == 16'd0 || w_len_over) begin
              r_err   <= w_len_over;
              r_state <= S_DONE;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            r_word <= {r_word[15:0], rx_byte};
            r_idx  <= r_idx + 2'd1;
`ifdef IMEM_CHECKSUM_EN
            r_chk  <= r_chk ^ rx_byte;
`endif
            if (r_idx == 2'd3) begin
              r_words <= w_words_nxt;
              if (w_last) begin
`ifdef IMEM_CHECKSUM_EN
                r_state <= S_CHK;
`else
                r_state <= S_DONE;
                r_hold  <= 1'b0;
                r_done  <= 1'b1;
`endif
              end
            end
          end
        end

`ifdef IMEM_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) begin
            if (rx_byte != r_chk) begin
              r_err <= 1'b1;
            end
            r_state <= S_DONE;
            r_hold  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign instruction_o = r_hold ? NOP_WORD : w_rdata;
  assign cpu_rst_o     = r_hold;
  assign load_busy     = r_hold;
  assign load_done     = r_done;
  assign load_err      = r_err;
  assign words_loaded  = r_words;

endmodule
